// File: rtl/alu_pkg.sv
// Shared ALU definitions for the pipelined adder/subtractor.
//   FLAG_* : bit positions of the Z/V/N/C flags in a packed flag vector
//   nstage : number of pipeline stages for a given width/slice split
//   smax/smin : signed saturation bounds for a given width (low WIDTH bits valid)
package alu_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 3;
  localparam int NFLAGS = 4;

  // Widest operand the saturation helpers can describe.
  localparam int MAX_W = 64;

  function automatic int nstage(input int width, input int slice);
    return width / slice;
  endfunction

  function automatic logic [MAX_W-1:0] smax(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_W-1:0] smin(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit carry-lookahead adder slice.
// Ports:
//   a, b  : slice operands (b already inverted by the caller for subtraction)
//   cin   : carry into bit 0 of the slice
//   sum   : slice sum
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (used for signed overflow in the top slice)
module cla_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [W-1:0] p_s;
  logic [W-1:0] g_s;
  logic [W:0]   c_s;
  logic         term_s;
  logic         cnx_s;

  assign p_s = a ^ b;
  assign g_s = a & b;

  // Each carry is a flat sum of products: the generate of any lower bit that
  // propagates all the way up, or cin propagated through every lower bit.
  always_comb begin
    c_s    = {(W + 1){1'b0}};
    term_s = 1'b0;
    cnx_s  = 1'b0;
    c_s[0] = cin;
    for (int i = 0; i < W; i++) begin
      cnx_s = cin;
      for (int m = 0; m <= i; m++) begin
        cnx_s = cnx_s & p_s[m];
      end
      for (int j = 0; j <= i; j++) begin
        term_s = g_s[j];
        for (int m = j + 1; m <= i; m++) begin
          term_s = term_s & p_s[m];
        end
        cnx_s = cnx_s | term_s;
      end
      c_s[i+1] = cnx_s;
    end
  end

  assign sum  = p_s ^ c_s[W-1:0];
  assign cout = c_s[W];
  assign cmsb = c_s[W-1];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with ALU flags and valid/ready
// handshakes. One SLICE-bit slice is resolved per stage; the carry between
// slices is registered. An input register and an output register bracket the
// slice stages so that the result appears NSTAGE cycles after acceptance.
// Optional build macro: ADD_SUB_PIPE_SAT_EN adds a 'sat' input that clamps
// overflowing results to the signed max/min.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready = pipeline may advance)
//   a, b, sub, in_tag   : operands, 1 = a-b, sideband tag
//   sat                 : (ADD_SUB_PIPE_SAT_EN only) saturate on overflow
//   out_valid/out_ready : output handshake
//   sum, cout, ovfl, zero, neg, out_tag : registered result, flags and tag
module add_sub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef ADD_SUB_PIPE_SAT_EN
  input  logic             sat,
`endif
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic             zero,
  output logic             neg,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NSTAGE = nstage(WIDTH, SLICE);

`ifdef ADD_SUB_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin(WIDTH));
  logic [NSTAGE-1:0] sat_r;
`endif

  // Stage register k feeds slice k. Bits of a_r/b_r below slice k and bits
  // of sum_r at or above slice k are don't-care.
  logic [NSTAGE-1:0] vld_r;
  logic [NSTAGE-1:0] cin_r;
  logic [TAG_W-1:0]  tag_r [NSTAGE];
  logic [WIDTH-1:0]  a_r   [NSTAGE];
  logic [WIDTH-1:0]  b_r   [NSTAGE];
  logic [WIDTH-1:0]  sum_r [NSTAGE];

  logic [SLICE-1:0]  sl_sum_s  [NSTAGE];
  logic [NSTAGE-1:0] sl_cout_s;
  logic [NSTAGE-1:0] sl_cmsb_s;
  logic [WIDTH-1:0]  sum_nx_s  [NSTAGE];

  logic              advance_s;
  logic              ovf_s;
  logic [WIDTH-1:0]  res_s;
  logic [NFLAGS-1:0] flags_s;

  // Whole pipeline moves together; it only freezes when a result is waiting.
  assign advance_s = out_ready | ~out_valid;
  assign in_ready  = advance_s;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_slice
    cla_slice #(.W(SLICE)) u_slice (
      .a    (a_r[k][k*SLICE +: SLICE]),
      .b    (b_r[k][k*SLICE +: SLICE]),
      .cin  (cin_r[k]),
      .sum  (sl_sum_s[k]),
      .cout (sl_cout_s[k]),
      .cmsb (sl_cmsb_s[k])
    );
  end

  // Merge each slice result into the partial sum carried down the pipe.
  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      sum_nx_s[k] = sum_r[k];
      sum_nx_s[k][k*SLICE +: SLICE] = sl_sum_s[k];
    end
  end

  // Final-stage result selection (optional clamp) and flag generation.
  always_comb begin
    ovf_s = sl_cmsb_s[NSTAGE-1] ^ sl_cout_s[NSTAGE-1];
    res_s = sum_nx_s[NSTAGE-1];
`ifdef ADD_SUB_PIPE_SAT_EN
    // On overflow the wrapped MSB is the inverse of the true sign.
    if (sat_r[NSTAGE-1] && ovf_s) begin
      if (sum_nx_s[NSTAGE-1][WIDTH-1]) begin
        res_s = SMAX;
      end else begin
        res_s = SMIN;
      end
    end else begin
      res_s = sum_nx_s[NSTAGE-1];
    end
`endif
    flags_s         = {NFLAGS{1'b0}};
    flags_s[FLAG_Z] = (res_s == {WIDTH{1'b0}});
    flags_s[FLAG_V] = ovf_s;
    flags_s[FLAG_N] = res_s[WIDTH-1];
    flags_s[FLAG_C] = sl_cout_s[NSTAGE-1];
  end

  // Pipeline and output registers; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r     <= {NSTAGE{1'b0}};
      cin_r     <= {NSTAGE{1'b0}};
`ifdef ADD_SUB_PIPE_SAT_EN
      sat_r     <= {NSTAGE{1'b0}};
`endif
      for (int k = 0; k < NSTAGE; k++) begin
        tag_r[k] <= {TAG_W{1'b0}};
        a_r[k]   <= {WIDTH{1'b0}};
        b_r[k]   <= {WIDTH{1'b0}};
        sum_r[k] <= {WIDTH{1'b0}};
      end
      out_valid <= 1'b0;
      sum       <= {WIDTH{1'b0}};
      cout      <= 1'b0;
      ovfl      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      out_tag   <= {TAG_W{1'b0}};
    end else if (advance_s) begin
      // Subtraction is a + ~b + 1: invert b once here, carry-in of slice 0.
      vld_r[0] <= in_valid;
      cin_r[0] <= sub;
      a_r[0]   <= a;
      b_r[0]   <= sub ? ~b : b;
      tag_r[0] <= in_tag;
      sum_r[0] <= {WIDTH{1'b0}};
`ifdef ADD_SUB_PIPE_SAT_EN
      sat_r[0] <= sat;
`endif
      for (int k = 1; k < NSTAGE; k++) begin
        vld_r[k] <= vld_r[k-1];
        cin_r[k] <= sl_cout_s[k-1];
        a_r[k]   <= a_r[k-1];
        b_r[k]   <= b_r[k-1];
        tag_r[k] <= tag_r[k-1];
        sum_r[k] <= sum_nx_s[k-1];
`ifdef ADD_SUB_PIPE_SAT_EN
        sat_r[k] <= sat_r[k-1];
`endif
      end
      out_valid <= vld_r[NSTAGE-1];
      sum       <= res_s;
      cout      <= flags_s[FLAG_C];
      ovfl      <= flags_s[FLAG_V];
      zero      <= flags_s[FLAG_Z];
      neg       <= flags_s[FLAG_N];
      out_tag   <= tag_r[NSTAGE-1];
    end
  end

endmodule
